// File: rtl/riscv_4bit_pkg.sv
// Shared encodings for the 4-bit RISC-V-style core: opcodes, ALU ops,
// sequencer states and instruction field positions.
package riscv_4bit_pkg;

    localparam int unsigned InstrW = 12;
    localparam int unsigned OpMsb  = 11;
    localparam int unsigned OpLsb  = 8;
    localparam int unsigned RdMsb  = 7;
    localparam int unsigned RdLsb  = 6;
    localparam int unsigned Rs1Msb = 5;
    localparam int unsigned Rs1Lsb = 4;
    localparam int unsigned ImmMsb = 3;
    localparam int unsigned ImmLsb = 0;
    localparam int unsigned Rs2Msb = 1;
    localparam int unsigned Rs2Lsb = 0;

    typedef enum logic [3:0] {
        OpAdd  = 4'h0,
        OpSub  = 4'h1,
        OpAnd  = 4'h2,
        OpOr   = 4'h3,
        OpAddi = 4'h4,
        OpLi   = 4'h5,
        OpBeqz = 4'h6,
        OpJmp  = 4'h7,
        OpHalt = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        AluAdd   = 3'd0,
        AluSub   = 3'd1,
        AluAnd   = 3'd2,
        AluOr    = 3'd3,
        AluPassA = 3'd4,
        AluPassB = 3'd5
    } alu_op_e;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StFetch     = 3'd1,
        StDecode    = 3'd2,
        StExecute   = 3'd3,
        StWriteback = 3'd4,
        StPause     = 3'd5,
        StHalt      = 3'd6
    } state_e;

endpackage

// File: rtl/riscv_4bit_decoder.sv
// Combinational opcode decoder: maps the IR opcode field to ALU controls
// and instruction class flags used by the sequencer.
module riscv_4bit_decoder
    import riscv_4bit_pkg::*;
(
    input  logic [3:0] op_i,
    output alu_op_e    alu_op_o,
    output logic       alu_src_imm_o,
    output logic       writes_rd_o,
    output logic       is_branch_o,
    output logic       is_jump_o,
    output logic       is_halt_o,
    output logic       is_illegal_o
);

    always_comb begin
        alu_op_o      = AluAdd;
        alu_src_imm_o = 1'b0;
        writes_rd_o   = 1'b0;
        is_branch_o   = 1'b0;
        is_jump_o     = 1'b0;
        is_halt_o     = 1'b0;
        is_illegal_o  = 1'b0;
        case (op_i)
            OpAdd:  writes_rd_o = 1'b1;
            OpSub: begin
                alu_op_o    = AluSub;
                writes_rd_o = 1'b1;
            end
            OpAnd: begin
                alu_op_o    = AluAnd;
                writes_rd_o = 1'b1;
            end
            OpOr: begin
                alu_op_o    = AluOr;
                writes_rd_o = 1'b1;
            end
            OpAddi: begin
                alu_src_imm_o = 1'b1;
                writes_rd_o   = 1'b1;
            end
            OpLi: begin
                alu_op_o      = AluPassB;
                alu_src_imm_o = 1'b1;
                writes_rd_o   = 1'b1;
            end
            OpBeqz: begin
                alu_op_o    = AluPassA;
                is_branch_o = 1'b1;
            end
            OpJmp:  is_jump_o = 1'b1;
            OpHalt: is_halt_o = 1'b1;
            default: is_illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/riscv_4bit_control_fsm.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the 4-bit core.
// Owns PC, IR, the retired counter and the sticky illegal flag.
module riscv_4bit_control_fsm
    import riscv_4bit_pkg::*;
#(
    parameter int unsigned PC_W    = 4,
    parameter int unsigned INSTR_W = 12,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               step_mode,
    input  logic               step,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [1:0]         rf_raddr1,
    output logic [1:0]         rf_raddr2,
    output logic [1:0]         rf_waddr,
    output logic               rf_we,
    output logic [2:0]         alu_op,
    output logic               alu_src_imm,
    output logic [3:0]         imm,
    input  logic               alu_zero,
    output logic [PC_W-1:0]    pc,
    output logic [2:0]         state,
    output logic               halted,
    output logic               illegal,
    output logic [CNT_W-1:0]   retired
);

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               illegal_q, illegal_d;
    logic               zero_q, zero_d;

    alu_op_e dec_alu_op;
    logic    dec_src_imm;
    logic    dec_writes_rd;
    logic    dec_is_branch;
    logic    dec_is_jump;
    logic    dec_is_halt;
    logic    dec_is_illegal;

    riscv_4bit_decoder u_decoder (
        .op_i          (ir_q[OpMsb:OpLsb]),
        .alu_op_o      (dec_alu_op),
        .alu_src_imm_o (dec_src_imm),
        .writes_rd_o   (dec_writes_rd),
        .is_branch_o   (dec_is_branch),
        .is_jump_o     (dec_is_jump),
        .is_halt_o     (dec_is_halt),
        .is_illegal_o  (dec_is_illegal)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        retired_d   = retired_q;
        illegal_d   = illegal_q;
        zero_d      = zero_q;
        imem_req    = 1'b0;
        rf_we       = 1'b0;
        alu_op      = '0;
        alu_src_imm = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StFetch;
            end
            StFetch: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (dec_is_halt) begin
                    state_d = StHalt;
                end else if (dec_is_illegal) begin
                    state_d   = StHalt;
                    illegal_d = 1'b1;
                end else begin
                    state_d = StExecute;
                end
            end
            StExecute: begin
                alu_op      = dec_alu_op;
                alu_src_imm = dec_src_imm;
                zero_d      = alu_zero;
                state_d     = StWriteback;
            end
            StWriteback: begin
                // Controls stay valid so the register file sees a stable result on rf_we.
                alu_op      = dec_alu_op;
                alu_src_imm = dec_src_imm;
                rf_we       = dec_writes_rd;
                if (dec_is_jump || (dec_is_branch && zero_q)) begin
                    pc_d = PC_W'(ir_q[ImmMsb:ImmLsb]);
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
                if (retired_q != '1) retired_d = retired_q + CNT_W'(1);
                state_d = step_mode ? StPause : StFetch;
            end
            StPause: begin
                if (step) state_d = StFetch;
            end
            StHalt: begin
                if (start) begin
                    state_d   = StFetch;
                    pc_d      = '0;
                    retired_d = '0;
                    illegal_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            pc_q      <= '0;
            ir_q      <= '0;
            retired_q <= '0;
            illegal_q <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
            zero_q    <= zero_d;
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign rf_raddr1 = ir_q[Rs1Msb:Rs1Lsb];
    assign rf_raddr2 = ir_q[Rs2Msb:Rs2Lsb];
    assign rf_waddr  = ir_q[RdMsb:RdLsb];
    assign imm       = ir_q[ImmMsb:ImmLsb];
    assign state     = state_q;
    assign halted    = (state_q == StHalt);
    assign illegal   = illegal_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_riscv_4bit_control_fsm.sv
// Directed bench for the sequencer: a vector table of single instructions
// reached via a JMP, plus hand-written program, wait-state, pause and reset sequences.
module tb_riscv_4bit_control_fsm;

    localparam int S_IDLE  = 0;
    localparam int S_FETCH = 1;
    localparam int S_EXEC  = 3;
    localparam int S_PAUSE = 5;
    localparam int S_HALT  = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        step_mode = 1'b0;
    logic        step = 1'b0;
    logic        imem_ready = 1'b0;
    logic [11:0] imem_rdata = '0;
    logic        alu_zero = 1'b0;
    logic        imem_req;
    logic [3:0]  imem_addr;
    logic [1:0]  rf_raddr1, rf_raddr2, rf_waddr;
    logic        rf_we;
    logic [2:0]  alu_op;
    logic        alu_src_imm;
    logic [3:0]  imm;
    logic [3:0]  pc;
    logic [2:0]  state;
    logic        halted;
    logic        illegal;
    logic [7:0]  retired;

    riscv_4bit_control_fsm dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .step_mode   (step_mode),
        .step        (step),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .rf_raddr1   (rf_raddr1),
        .rf_raddr2   (rf_raddr2),
        .rf_waddr    (rf_waddr),
        .rf_we       (rf_we),
        .alu_op      (alu_op),
        .alu_src_imm (alu_src_imm),
        .imm         (imm),
        .alu_zero    (alu_zero),
        .pc          (pc),
        .state       (state),
        .halted      (halted),
        .illegal     (illegal),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    logic [11:0] mem [16];
    int          wait_cycles = 0;
    int          wcnt = 0;
    bit          mon_en = 1'b0;
    int          viol = 0;
    logic        prev_req = 1'b0;
    logic        prev_ready = 1'b0;
    logic [3:0]  prev_addr = '0;

    // Instruction memory responder with programmable wait states and a stability monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && prev_req && !prev_ready && (!imem_req || imem_addr != prev_addr)) viol++;
            if (imem_req) begin
                if (wcnt >= wait_cycles) begin
                    imem_ready = 1'b1;
                    imem_rdata = mem[imem_addr];
                    wcnt       = 0;
                end else begin
                    imem_ready = 1'b0;
                    wcnt++;
                end
            end else begin
                imem_ready = 1'b0;
                wcnt       = 0;
            end
            prev_req   = imem_req;
            prev_addr  = imem_addr;
            prev_ready = imem_ready;
        end
    end

    int n_cmp = 0;
    int n_fail = 0;
    int we_cnt, ex_alu, ex_src;
    int we_waddr [3];
    int we_alu [3];
    int we_ra1 [3];
    int we_ra2 [3];
    int we_imm [3];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_obs();
        we_cnt = 0;
        ex_alu = -1;
        ex_src = -1;
        for (int k = 0; k < 3; k++) begin
            we_waddr[k] = -1;
            we_alu[k]   = -1;
            we_ra1[k]   = -1;
            we_ra2[k]   = -1;
            we_imm[k]   = -1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (int'(state) == S_EXEC) begin
            ex_alu = int'(alu_op);
            ex_src = int'(alu_src_imm);
        end
        if (rf_we) begin
            if (we_cnt < 3) begin
                we_waddr[we_cnt] = int'(rf_waddr);
                we_alu[we_cnt]   = int'(alu_op);
                we_ra1[we_cnt]   = int'(rf_raddr1);
                we_ra2[we_cnt]   = int'(rf_raddr2);
                we_imm[we_cnt]   = int'(imm);
            end
            we_cnt++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        start = 1'b0;
        step  = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        clear_obs();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_step();
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    task automatic run_to_halt(output int cyc);
        cyc = 0;
        while (!halted && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask

    task automatic run_to_park();
        int c = 0;
        while (int'(state) != S_PAUSE && int'(state) != S_HALT && c < 60) begin
            tick();
            c++;
        end
    endtask

    task automatic load_prog_a();
        for (int k = 0; k < 16; k++) mem[k] = 12'hF00;
        mem[0] = 12'h543;  // LI r1,3
        mem[1] = 12'h585;  // LI r2,5
        mem[2] = 12'h0D2;  // ADD r3,r1,r2
        mem[3] = 12'hF00;  // HALT
    endtask

    typedef struct {
        logic [11:0] instr;
        int          p;
        bit          zero;
        int          exp_pc;
        int          exp_we;
        bit          chk_alu;
        int          exp_alu;
        int          exp_src;
        int          exp_halt;
        int          exp_ill;
        int          exp_ret;
    } vec_t;

    vec_t vecs [14];

    initial begin
        int cyc;
        int v0;
        vecs[0]  = '{12'h0D2, 4,  1'b0, 5,  1, 1'b1, 0, 0, 0, 0, 2};  // ADD
        vecs[1]  = '{12'h163, 2,  1'b0, 3,  1, 1'b1, 1, 0, 0, 0, 2};  // SUB
        vecs[2]  = '{12'h2E5, 7,  1'b0, 8,  1, 1'b1, 2, 0, 0, 0, 2};  // AND
        vecs[3]  = '{12'h311, 9,  1'b0, 10, 1, 1'b1, 3, 0, 0, 0, 2};  // OR
        vecs[4]  = '{12'h4A7, 15, 1'b0, 0,  1, 1'b1, 0, 1, 0, 0, 2};  // ADDI at 15 wraps
        vecs[5]  = '{12'h549, 3,  1'b0, 4,  1, 1'b1, 5, 1, 0, 0, 2};  // LI
        vecs[6]  = '{12'h605, 2,  1'b1, 5,  0, 1'b1, 4, 0, 0, 0, 2};  // BEQZ taken
        vecs[7]  = '{12'h605, 2,  1'b0, 3,  0, 1'b1, 4, 0, 0, 0, 2};  // BEQZ not taken
        vecs[8]  = '{12'h700, 15, 1'b0, 0,  0, 1'b0, 0, 0, 0, 0, 2};  // JMP 0 at 15
        vecs[9]  = '{12'h703, 12, 1'b0, 3,  0, 1'b0, 0, 0, 0, 0, 2};  // JMP 3
        vecs[10] = '{12'h9C3, 6,  1'b0, 6,  0, 1'b0, 0, 0, 1, 1, 1};  // illegal 9
        vecs[11] = '{12'hE00, 5,  1'b0, 5,  0, 1'b0, 0, 0, 1, 1, 1};  // illegal E
        vecs[12] = '{12'hF00, 8,  1'b0, 8,  0, 1'b0, 0, 0, 1, 0, 1};  // HALT
        vecs[13] = '{12'h4F0, 1,  1'b0, 2,  1, 1'b1, 0, 1, 0, 0, 2};  // ADDI
        for (int k = 0; k < 16; k++) mem[k] = 12'hF00;

        // Reset state
        @(negedge clk);
        clear_obs();
        tick();
        tick();
        check("rst_state", int'(state), S_IDLE);
        check("rst_req", int'(imem_req), 0);
        check("rst_we", int'(rf_we), 0);
        check("rst_halted", int'(halted), 0);
        check("rst_illegal", int'(illegal), 0);
        check("rst_pc", int'(pc), 0);
        check("rst_retired", int'(retired), 0);
        check("rst_alu_op", int'(alu_op), 0);
        check("rst_src_imm", int'(alu_src_imm), 0);
        reset = 1'b1;

        // Vector table: JMP from 0 to p, then execute the instruction under test at p.
        step_mode = 1'b1;
        for (int i = 0; i < 14; i++) begin
            for (int k = 0; k < 16; k++) mem[k] = 12'hF00;
            mem[0] = 12'h700 | 12'(vecs[i].p);
            mem[vecs[i].p] = vecs[i].instr;
            alu_zero = vecs[i].zero;
            do_reset();
            pulse_start();
            run_to_park();
            check($sformatf("v%0d_jmp_state", i), int'(state), S_PAUSE);
            check($sformatf("v%0d_jmp_pc", i), int'(pc), vecs[i].p);
            clear_obs();
            pulse_step();
            run_to_park();
            check($sformatf("v%0d_pc", i), int'(pc), vecs[i].exp_pc);
            check($sformatf("v%0d_we_cnt", i), we_cnt, vecs[i].exp_we);
            if (vecs[i].chk_alu) begin
                check($sformatf("v%0d_alu_op", i), ex_alu, vecs[i].exp_alu);
                check($sformatf("v%0d_src_imm", i), ex_src, vecs[i].exp_src);
            end
            check($sformatf("v%0d_halted", i), int'(halted), vecs[i].exp_halt);
            check($sformatf("v%0d_illegal", i), int'(illegal), vecs[i].exp_ill);
            check($sformatf("v%0d_retired", i), int'(retired), vecs[i].exp_ret);
        end
        alu_zero = 1'b0;

        // Program A, zero-wait memory, free-run
        step_mode   = 1'b0;
        wait_cycles = 0;
        load_prog_a();
        do_reset();
        pulse_start();
        run_to_halt(cyc);
        check("a_cycles", cyc, 14);
        check("a_we_cnt", we_cnt, 3);
        check("a_we0_alu_passb", we_alu[0], 5);
        check("a_we0_imm", we_imm[0], 3);
        check("a_we0_waddr", we_waddr[0], 1);
        check("a_we2_waddr", we_waddr[2], 3);
        check("a_we2_alu_add", we_alu[2], 0);
        check("a_we2_ra1", we_ra1[2], 1);
        check("a_we2_ra2", we_ra2[2], 2);
        check("a_retired", int'(retired), 3);
        check("a_pc", int'(pc), 3);
        check("a_state", int'(state), S_HALT);
        check("a_halt_req", int'(imem_req), 0);

        // Program A with two wait states per fetch
        wait_cycles = 2;
        do_reset();
        v0     = viol;
        mon_en = 1'b1;
        pulse_start();
        run_to_halt(cyc);
        mon_en = 1'b0;
        check("b_cycles", cyc, 22);
        check("b_req_addr_stable", viol - v0, 0);
        check("b_we_cnt", we_cnt, 3);
        check("b_retired", int'(retired), 3);
        wait_cycles = 0;

        // Illegal opcode, then restart from HALT
        for (int k = 0; k < 16; k++) mem[k] = 12'hF00;
        mem[0] = 12'h9C3;
        do_reset();
        pulse_start();
        run_to_halt(cyc);
        check("ill_halted", int'(halted), 1);
        check("ill_flag", int'(illegal), 1);
        check("ill_we_cnt", we_cnt, 0);
        check("ill_retired", int'(retired), 0);
        mem[0] = 12'h543;
        pulse_start();
        check("ill_restart_state", int'(state), S_FETCH);
        check("ill_restart_flag", int'(illegal), 0);
        check("ill_restart_addr", int'(imem_addr), 0);
        check("ill_restart_req", int'(imem_req), 1);

        // Step mode: park in PAUSE, ignore start, advance on step
        step_mode = 1'b1;
        load_prog_a();
        do_reset();
        pulse_start();
        run_to_park();
        check("pause_state", int'(state), S_PAUSE);
        check("pause_pc", int'(pc), 1);
        pulse_start();
        tick();
        tick();
        tick();
        check("pause_start_ignored_state", int'(state), S_PAUSE);
        check("pause_start_ignored_pc", int'(pc), 1);
        check("pause_start_ignored_ret", int'(retired), 1);
        pulse_step();
        run_to_park();
        check("step2_state", int'(state), S_PAUSE);
        check("step2_pc", int'(pc), 2);
        check("step2_retired", int'(retired), 2);

        // Reset asserted while a fetch is waiting
        wait_cycles = 3;
        pulse_step();
        tick();
        check("midfetch_req", int'(imem_req), 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("midfetch_rst_state", int'(state), S_IDLE);
        check("midfetch_rst_req", int'(imem_req), 0);
        check("midfetch_rst_pc", int'(pc), 0);
        check("midfetch_rst_retired", int'(retired), 0);
        wait_cycles = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
